// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: push-button front end for the snake game core.
// Synchronises and debounces four raw buttons, turns debounced rising edges
// into turn requests, filters out reversals/duplicates, and buffers up to two
// pending turns that are committed one per move_tick.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   btn_u/btn_d/btn_l/btn_r    raw asynchronous push-buttons, active-high
//   enable                     game running; low flushes and ignores input
//   restart                    one-cycle pulse: heading to INIT_DIR, flush
//   move_tick                  one-cycle pulse per snake step
//   direction                  committed heading (00 L, 01 R, 10 U, 11 D)
//   queue_count                pending turns, 0..2
//   dir_changed                pulse after a tick that altered direction
//   press_drop                 pulse when a debounced press is rejected
module snake_dir_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20,
  parameter logic [1:0]  INIT_DIR        = 2'b01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       enable,
  input  logic       restart,
  input  logic       move_tick,
  output logic [1:0] direction,
  output logic [1:0] queue_count,
  output logic       dir_changed,
  output logic       press_drop
);

  localparam int unsigned NUM_BTN = 4;
  localparam logic [1:0] DIR_L = 2'b00;
  localparam logic [1:0] DIR_R = 2'b01;
  localparam logic [1:0] DIR_U = 2'b10;
  localparam logic [1:0] DIR_D = 2'b11;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit order: 0 = up, 1 = down, 2 = left, 3 = right.
  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] sync1, sync2, stable, stable_prev;
  logic [CNT_W-1:0]   cnt [NUM_BTN];
  logic [NUM_BTN-1:0] press;

  // Queue storage: head is the oldest entry, tail the youngest when full.
  logic [1:0] head, tail;

  logic [1:0] direction_nxt, count_nxt, head_nxt, tail_nxt;
  logic       changed_nxt, drop_nxt;
  logic       pop, reject;
  logic [1:0] req, ref_dir;

  assign raw   = {btn_r, btn_l, btn_d, btn_u};
  assign press = stable & ~stable_prev;

  // Two-flop synchroniser and per-button debounce filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= '0;
      sync2       <= '0;
      stable      <= '0;
      stable_prev <= '0;
      for (int i = 0; i < int'(NUM_BTN); i++) cnt[i] <= '0;
    end else begin
      sync1       <= raw;
      sync2       <= sync1;
      stable_prev <= stable;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Turn acceptance, queue update and commit on move_tick.
  always_comb begin
    direction_nxt = direction;
    count_nxt     = queue_count;
    head_nxt      = head;
    tail_nxt      = tail;
    changed_nxt   = 1'b0;
    drop_nxt      = 1'b0;
    pop           = 1'b0;
    reject        = 1'b0;

    // Highest-priority press wins; lower simultaneous presses vanish.
    if (press[0])      req = DIR_U;
    else if (press[1]) req = DIR_D;
    else if (press[2]) req = DIR_L;
    else               req = DIR_R;

    // Compare against where the snake will be heading after the queue drains.
    if (queue_count == 2'd2)      ref_dir = tail;
    else if (queue_count == 2'd1) ref_dir = head;
    else                          ref_dir = direction;

    if (restart) begin
      direction_nxt = INIT_DIR;
      count_nxt     = 2'd0;
    end else if (!enable) begin
      count_nxt = 2'd0;
    end else begin
      pop = move_tick && (queue_count != 2'd0);
      if (pop) begin
        direction_nxt = head;
        changed_nxt   = (head != direction);
        head_nxt      = tail;
        count_nxt     = queue_count - 2'd1;
      end
      if (|press) begin
        reject = (req == ref_dir) || (req == (ref_dir ^ 2'b01)) ||
                 ((queue_count == 2'd2) && !pop);
        if (reject) begin
          drop_nxt = 1'b1;
        end else begin
          if (count_nxt == 2'd0) head_nxt = req;
          else                   tail_nxt = req;
          count_nxt = count_nxt + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      direction   <= INIT_DIR;
      queue_count <= 2'd0;
      head        <= 2'd0;
      tail        <= 2'd0;
      dir_changed <= 1'b0;
      press_drop  <= 1'b0;
    end else begin
      direction   <= direction_nxt;
      queue_count <= count_nxt;
      head        <= head_nxt;
      tail        <= tail_nxt;
      dir_changed <= changed_nxt;
      press_drop  <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl with a short debounce window (4 cycles).
module tb_snake_dir_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;  // 0 up, 1 down, 2 left, 3 right
  logic       enable, restart, move_tick;
  logic [1:0] direction, queue_count;
  logic       dir_changed, press_drop;
  int         errors = 0;
  int         checks = 0;

  snake_dir_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3),
    .INIT_DIR(2'b01)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_u(btn[0]), .btn_d(btn[1]), .btn_l(btn[2]), .btn_r(btn[3]),
    .enable(enable), .restart(restart), .move_tick(move_tick),
    .direction(direction), .queue_count(queue_count),
    .dir_changed(dir_changed), .press_drop(press_drop)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise a button; returns just after the edge where its press takes effect.
  task automatic hold_btn(input int idx);
    btn[idx] = 1'b1;
    repeat (7) step();
  endtask

  task automatic release_btn(input int idx);
    btn[idx] = 1'b0;
    repeat (8) step();
  endtask

  task automatic tick();
    move_tick = 1'b1;
    step();
    move_tick = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn = '0; enable = 1'b1; restart = 1'b0; move_tick = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checks++; if (direction !== 2'b01) begin errors++; $display("FAIL reset_dir got=%b exp=01", direction); end
    checks++; if (queue_count !== 2'd0) begin errors++; $display("FAIL reset_qc got=%0d exp=0", queue_count); end
    checks++; if (dir_changed !== 1'b0) begin errors++; $display("FAIL reset_dc got=%b exp=0", dir_changed); end
    checks++; if (press_drop !== 1'b0) begin errors++; $display("FAIL reset_pd got=%b exp=0", press_drop); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (direction !== 2'b01 || queue_count !== 2'd0) begin
      errors++; $display("FAIL reset_midcycle got dir=%b qc=%0d exp dir=01 qc=0", direction, queue_count); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_latency_tick();
    btn[0] = 1'b1;
    repeat (6) step();
    checks++; if (queue_count !== 2'd0) begin errors++; $display("FAIL lat_early_qc got=%0d exp=0", queue_count); end
    step();
    checks++; if (queue_count !== 2'd1) begin errors++; $display("FAIL lat_qc got=%0d exp=1", queue_count); end
    checks++; if (press_drop !== 1'b0) begin errors++; $display("FAIL lat_pd got=%b exp=0", press_drop); end
    repeat (5) step();
    release_btn(0);
    tick();
    checks++; if (direction !== 2'b10) begin errors++; $display("FAIL tick_dir got=%b exp=10", direction); end
    checks++; if (queue_count !== 2'd0) begin errors++; $display("FAIL tick_qc got=%0d exp=0", queue_count); end
    checks++; if (dir_changed !== 1'b1) begin errors++; $display("FAIL tick_dc got=%b exp=1", dir_changed); end
    step();
    checks++; if (dir_changed !== 1'b0) begin errors++; $display("FAIL tick_dc_one got=%b exp=0", dir_changed); end
  endtask

  task automatic test_bounce();
    int bad = 0;
    pulse_restart();
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) btn[3] = ~btn[3];
      step();
      if (queue_count !== 2'd0 || press_drop !== 1'b0) bad++;
    end
    btn[3] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (queue_count !== 2'd0 || press_drop !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bounce_quiet got=%0d bad cycles exp=0", bad); end
    checks++; if (direction !== 2'b01) begin errors++; $display("FAIL bounce_dir got=%b exp=01", direction); end
  endtask

  task automatic test_reject();
    hold_btn(2);
    checks++; if (press_drop !== 1'b1) begin errors++; $display("FAIL rev_pd got=%b exp=1", press_drop); end
    checks++; if (queue_count !== 2'd0) begin errors++; $display("FAIL rev_qc got=%0d exp=0", queue_count); end
    step();
    checks++; if (press_drop !== 1'b0) begin errors++; $display("FAIL rev_pd_one got=%b exp=0", press_drop); end
    release_btn(2);
    hold_btn(3);
    checks++; if (press_drop !== 1'b1 || queue_count !== 2'd0) begin
      errors++; $display("FAIL dup got pd=%b qc=%0d exp pd=1 qc=0", press_drop, queue_count); end
    release_btn(3);
  endtask

  task automatic test_queue();
    hold_btn(0);
    checks++; if (queue_count !== 2'd1) begin errors++; $display("FAIL q_u got=%0d exp=1", queue_count); end
    release_btn(0);
    hold_btn(2);
    checks++; if (queue_count !== 2'd2) begin errors++; $display("FAIL q_l got=%0d exp=2", queue_count); end
    release_btn(2);
    hold_btn(1);
    checks++; if (press_drop !== 1'b1 || queue_count !== 2'd2) begin
      errors++; $display("FAIL q_full got pd=%b qc=%0d exp pd=1 qc=2", press_drop, queue_count); end
    release_btn(1);
    tick();
    checks++; if (direction !== 2'b10 || queue_count !== 2'd1 || dir_changed !== 1'b1) begin
      errors++; $display("FAIL q_tick1 got dir=%b qc=%0d dc=%b exp 10/1/1", direction, queue_count, dir_changed); end
    step();
    tick();
    checks++; if (direction !== 2'b00 || queue_count !== 2'd0 || dir_changed !== 1'b1) begin
      errors++; $display("FAIL q_tick2 got dir=%b qc=%0d dc=%b exp 00/0/1", direction, queue_count, dir_changed); end
    step();
    tick();
    checks++; if (direction !== 2'b00 || dir_changed !== 1'b0) begin
      errors++; $display("FAIL q_tick3 got dir=%b dc=%b exp 00/0", direction, dir_changed); end
  endtask

  task automatic test_back_to_back();
    pulse_restart();
    hold_btn(0); release_btn(0);
    hold_btn(2); release_btn(2);
    checks++; if (queue_count !== 2'd2) begin errors++; $display("FAIL b2b_fill got=%0d exp=2", queue_count); end
    btn[1] = 1'b1;
    repeat (6) step();
    tick();
    checks++; if (direction !== 2'b10 || queue_count !== 2'd2 || press_drop !== 1'b0 || dir_changed !== 1'b1) begin
      errors++; $display("FAIL b2b_pushpop got dir=%b qc=%0d pd=%b dc=%b exp 10/2/0/1",
                         direction, queue_count, press_drop, dir_changed); end
    btn[1] = 1'b0;
    enable = 1'b0;
    step();
    checks++; if (queue_count !== 2'd0 || direction !== 2'b10) begin
      errors++; $display("FAIL dis_flush got qc=%0d dir=%b exp 0/10", queue_count, direction); end
    tick();
    checks++; if (direction !== 2'b10 || dir_changed !== 1'b0) begin
      errors++; $display("FAIL dis_tick got dir=%b dc=%b exp 10/0", direction, dir_changed); end
    hold_btn(2);
    checks++; if (queue_count !== 2'd0 || press_drop !== 1'b0) begin
      errors++; $display("FAIL dis_press got qc=%0d pd=%b exp 0/0", queue_count, press_drop); end
    release_btn(2);
    enable = 1'b1;
    pulse_restart();
    checks++; if (direction !== 2'b01 || queue_count !== 2'd0) begin
      errors++; $display("FAIL restart got dir=%b qc=%0d exp 01/0", direction, queue_count); end
    // Restart coinciding with a tick must discard the tick.
    hold_btn(0); release_btn(0);
    restart = 1'b1; move_tick = 1'b1;
    step();
    restart = 1'b0; move_tick = 1'b0;
    checks++; if (direction !== 2'b01 || queue_count !== 2'd0 || dir_changed !== 1'b0) begin
      errors++; $display("FAIL restart_tick got dir=%b qc=%0d dc=%b exp 01/0/0", direction, queue_count, dir_changed); end
  endtask

  task automatic test_async_reset();
    hold_btn(0); release_btn(0);
    tick();
    hold_btn(2); release_btn(2);
    checks++; if (direction !== 2'b10 || queue_count !== 2'd1) begin
      errors++; $display("FAIL ar_setup got dir=%b qc=%0d exp 10/1", direction, queue_count); end
    btn[0] = 1'b1;
    repeat (3) step();
    #3 rst_n = 1'b0;
    #1;
    checks++; if (direction !== 2'b01 || queue_count !== 2'd0 || dir_changed !== 1'b0 || press_drop !== 1'b0) begin
      errors++; $display("FAIL ar_clear got dir=%b qc=%0d dc=%b pd=%b exp 01/0/0/0",
                         direction, queue_count, dir_changed, press_drop); end
    step();
    rst_n = 1'b1;
    repeat (6) step();
    checks++; if (queue_count !== 2'd0) begin errors++; $display("FAIL ar_refilter got=%0d exp=0", queue_count); end
    step();
    checks++; if (queue_count !== 2'd1) begin errors++; $display("FAIL ar_press got=%0d exp=1", queue_count); end
    release_btn(0);
  endtask

  initial begin
    test_reset();
    test_latency_tick();
    test_bounce();
    test_reject();
    test_queue();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
